// File: rtl/tempsens_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tempsens_ctrl_pkg : register offsets, channel FSM states, FIFO entry  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package tempsens_ctrl_pkg;

    localparam logic [7:0] ADDR_CTRL        = 8'h00;
    localparam logic [7:0] ADDR_START       = 8'h04;
    localparam logic [7:0] ADDR_CONV_TIME   = 8'h08;
    localparam logic [7:0] ADDR_STATUS      = 8'h0C;
    localparam logic [7:0] ADDR_FIFO_DATA   = 8'h10;
    localparam logic [7:0] ADDR_FIFO_LEVEL  = 8'h14;
    localparam logic [7:0] ADDR_ALARM       = 8'h18;
    localparam logic [7:0] ADDR_ALARM_EN    = 8'h1C;
    localparam logic [7:0] ADDR_THRESH      = 8'h20;
    localparam logic [7:0] ADDR_TIMEOUT     = 8'h24;
    localparam logic [7:0] ADDR_TIMEOUT_VAL = 8'h28;
    localparam logic [7:0] ADDR_OVF_CLR     = 8'h2C;

    // Widest result that still leaves room for the 8-bit channel tag.
    localparam int MAX_DOUT_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RST  = 2'd1,
        ST_CONV = 2'd2,
        ST_CAPT = 2'd3
    } ch_state_e;

    typedef struct packed {
        logic [7:0]            ch;
        logic [MAX_DOUT_W-1:0] data;
    } fifo_entry_t;

endpackage
`default_nettype wire

// File: rtl/tempsens_ch_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tempsens_ch_fsm : one sensor channel - done sync, FSM, timeout, hold |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tempsens_ch_fsm
    import tempsens_ctrl_pkg::*;
#(
    parameter int DoutW    = 24,
    parameter int TimeoutW = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                global_en,
    input  logic                continuous,
    input  logic                start,
    input  logic [TimeoutW-1:0] timeout_val,
    input  logic                done_async,
    input  logic [DoutW-1:0]    dout_async,
    input  logic                grant,
    output logic                sens_rst_n,
    output logic                sens_en,
    output logic                busy,
    output logic                req,
    output logic [DoutW-1:0]    result,
    output logic                timeout_hit
);

    ch_state_e           state;
    ch_state_e           state_nxt;
    logic                rst_cnt;
    logic                rst_cnt_nxt;
    logic [TimeoutW-1:0] tmo_cnt;
    logic [TimeoutW-1:0] tmo_cnt_nxt;
    logic [TimeoutW-1:0] tmo_inc;
    logic [2:0]          done_sync;
    logic                done_rise;
    logic                capture;

    // Stages 0/1 resynchronise; stage 2 only serves the rising-edge detect.
    assign done_rise = done_sync[1] & ~done_sync[2];
    assign tmo_inc   = tmo_cnt + TimeoutW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rst_cnt   <= 1'b0;
            tmo_cnt   <= '0;
            done_sync <= '0;
            result    <= '0;
        end else begin
            state     <= state_nxt;
            rst_cnt   <= rst_cnt_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            done_sync <= {done_sync[1:0], done_async};
            if (capture) begin
                result <= dout_async;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        tmo_cnt_nxt = tmo_cnt;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt   = ST_RST;
                    rst_cnt_nxt = 1'b0;
                end
            end
            ST_RST: begin
                if (rst_cnt) begin
                    state_nxt   = ST_CONV;
                    tmo_cnt_nxt = '0;
                end else begin
                    rst_cnt_nxt = 1'b1;
                end
            end
            ST_CONV: begin
                // A done edge in the final counted cycle still wins over timeout.
                if (done_rise) begin
                    state_nxt = ST_CAPT;
                    capture   = 1'b1;
                end else if (tmo_inc == timeout_val) begin
                    state_nxt   = ST_IDLE;
                    timeout_hit = 1'b1;
                end else begin
                    tmo_cnt_nxt = tmo_inc;
                end
            end
            ST_CAPT: begin
                if (grant) begin
                    state_nxt   = continuous ? ST_RST : ST_IDLE;
                    rst_cnt_nxt = 1'b0;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (!global_en) begin
            state_nxt   = ST_IDLE;
            capture     = 1'b0;
            timeout_hit = 1'b0;
        end
    end

    assign sens_rst_n = (state == ST_CONV) || (state == ST_CAPT);
    assign sens_en    = (state == ST_CONV);
    assign busy       = (state != ST_IDLE);
    assign req        = (state == ST_CAPT) && global_en;

endmodule
`default_nettype wire

// File: rtl/tempsens_ctrl_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tempsens_ctrl_multi : multi-channel temp-sensor controller, reg bus  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tempsens_ctrl_multi
    import tempsens_ctrl_pkg::*;
#(
    parameter int NumCh     = 4,
    parameter int DoutW     = 24,
    parameter int ConvW     = 4,
    parameter int FifoDepth = 8,
    parameter int TimeoutW  = 16,
    parameter int RegAw     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     re_i,
    input  logic                     we_i,
    input  logic [RegAw-1:0]         addr_i,
    input  logic [31:0]              wdata_i,
    input  logic [3:0]               be_i,
    output logic [31:0]              rdata_o,
    output logic                     error_o,
    output logic [NumCh-1:0]         sens_rst_no,
    output logic [NumCh-1:0]         sens_en_o,
    output logic [NumCh*ConvW-1:0]   sens_conv_time_o,
    input  logic [NumCh*DoutW-1:0]   sens_dout_i,
    input  logic [NumCh-1:0]         sens_done_i,
    output logic                     intr_o
);

    localparam int ChW    = (NumCh > 1) ? $clog2(NumCh) : 1;
    localparam int FifoAw = $clog2(FifoDepth);
    localparam int LvlW   = FifoAw + 1;

    logic                   global_en;
    logic                   continuous;
    logic [NumCh*ConvW-1:0] conv_time;
    logic [NumCh-1:0]       alarm;
    logic [NumCh-1:0]       alarm_en;
    logic [NumCh-1:0]       timeout;
    logic [DoutW-1:0]       thresh;
    logic [TimeoutW-1:0]    timeout_val;
    logic                   overflow;

    logic is_ctrl, is_start, is_conv, is_status, is_fdata, is_flevel;
    logic is_alarm, is_alarm_en, is_thresh, is_timeout, is_tmo_val, is_ovf_clr;
    logic mapped;
    logic wr;
    logic unused_wdata;

    assign wr           = we_i & (|be_i);
    assign unused_wdata = ^wdata_i;

    assign is_ctrl     = (addr_i == RegAw'(ADDR_CTRL));
    assign is_start    = (addr_i == RegAw'(ADDR_START));
    assign is_conv     = (addr_i == RegAw'(ADDR_CONV_TIME));
    assign is_status   = (addr_i == RegAw'(ADDR_STATUS));
    assign is_fdata    = (addr_i == RegAw'(ADDR_FIFO_DATA));
    assign is_flevel   = (addr_i == RegAw'(ADDR_FIFO_LEVEL));
    assign is_alarm    = (addr_i == RegAw'(ADDR_ALARM));
    assign is_alarm_en = (addr_i == RegAw'(ADDR_ALARM_EN));
    assign is_thresh   = (addr_i == RegAw'(ADDR_THRESH));
    assign is_timeout  = (addr_i == RegAw'(ADDR_TIMEOUT));
    assign is_tmo_val  = (addr_i == RegAw'(ADDR_TIMEOUT_VAL));
    assign is_ovf_clr  = (addr_i == RegAw'(ADDR_OVF_CLR));
    assign mapped = |{is_ctrl, is_start, is_conv, is_status, is_fdata, is_flevel,
                      is_alarm, is_alarm_en, is_thresh, is_timeout, is_tmo_val, is_ovf_clr};

    // ---------------- channels ----------------
    logic [NumCh-1:0] start_vec;
    logic [NumCh-1:0] busy;
    logic [NumCh-1:0] req;
    logic [NumCh-1:0] grant;
    logic [NumCh-1:0] timeout_hit;
    logic [DoutW-1:0] ch_result [NumCh];

    assign start_vec = (wr && is_start && global_en) ? wdata_i[NumCh-1:0] : '0;

    for (genvar n = 0; n < NumCh; n++) begin : g_ch
        tempsens_ch_fsm #(
            .DoutW    (DoutW),
            .TimeoutW (TimeoutW)
        ) u_fsm (
            .clk         (clk_i),
            .rst_n       (rst_ni),
            .global_en   (global_en),
            .continuous  (continuous),
            .start       (start_vec[n]),
            .timeout_val (timeout_val),
            .done_async  (sens_done_i[n]),
            .dout_async  (sens_dout_i[n*DoutW +: DoutW]),
            .grant       (grant[n]),
            .sens_rst_n  (sens_rst_no[n]),
            .sens_en     (sens_en_o[n]),
            .busy        (busy[n]),
            .req         (req[n]),
            .result      (ch_result[n]),
            .timeout_hit (timeout_hit[n])
        );
    end

    // Round-robin: search upward from rr_ptr, grant the first requester.
    logic [ChW-1:0] rr_ptr;
    logic [ChW-1:0] gnt_idx;
    logic [ChW-1:0] idx;
    logic           found;
    int             tmp;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        tmp     = 0;
        idx     = '0;
        for (int i = 0; i < NumCh; i++) begin
            tmp = int'(rr_ptr) + i;
            if (tmp >= NumCh) begin
                tmp = tmp - NumCh;
            end
            idx = ChW'(tmp);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gnt_idx    = idx;
            end
        end
    end

    // ---------------- result FIFO ----------------
    fifo_entry_t       mem [FifoDepth];
    fifo_entry_t       push_entry;
    logic [FifoAw-1:0] wptr;
    logic [FifoAw-1:0] rptr;
    logic [LvlW-1:0]   level;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    logic              push_do;
    logic              ovf_set;
    logic [31:0]       fifo_word;
    logic [NumCh-1:0]  alarm_set;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == LvlW'(FifoDepth));
    assign pop        = re_i && is_fdata && !fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_do    = found && (!fifo_full || pop);
    assign ovf_set    = found && fifo_full && !pop;

    assign push_entry.ch   = 8'(gnt_idx);
    assign push_entry.data = MAX_DOUT_W'(ch_result[gnt_idx]);
    assign fifo_word       = (32'(mem[rptr].ch) << DoutW) | 32'(mem[rptr].data);
    assign alarm_set       = (push_do && (ch_result[gnt_idx] > thresh)) ? grant : '0;

    always_ff @(posedge clk_i) begin
        if (push_do) begin
            mem[wptr] <= push_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            rr_ptr <= '0;
        end else begin
            if (push_do) begin
                wptr <= wptr + FifoAw'(1);
            end
            if (pop) begin
                rptr <= rptr + FifoAw'(1);
            end
            case ({push_do, pop})
                2'b10:   level <= level + LvlW'(1);
                2'b01:   level <= level - LvlW'(1);
                default: level <= level;
            endcase
            if (found) begin
                rr_ptr <= (gnt_idx == ChW'(NumCh - 1)) ? '0 : gnt_idx + ChW'(1);
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            global_en   <= 1'b0;
            continuous  <= 1'b0;
            conv_time   <= '0;
            alarm       <= '0;
            alarm_en    <= '0;
            thresh      <= '0;
            timeout     <= '0;
            timeout_val <= '1;
            overflow    <= 1'b0;
        end else begin
            if (wr && is_ctrl) begin
                {continuous, global_en} <= wdata_i[1:0];
            end
            if (wr && is_conv) begin
                conv_time <= wdata_i[NumCh*ConvW-1:0];
            end
            if (wr && is_alarm_en) begin
                alarm_en <= wdata_i[NumCh-1:0];
            end
            if (wr && is_thresh) begin
                thresh <= wdata_i[DoutW-1:0];
            end
            if (wr && is_tmo_val) begin
                timeout_val <= wdata_i[TimeoutW-1:0];
            end
            alarm   <= (alarm & ~((wr && is_alarm) ? wdata_i[NumCh-1:0] : '0)) | alarm_set;
            timeout <= (timeout & ~((wr && is_timeout) ? wdata_i[NumCh-1:0] : '0)) | timeout_hit;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (wr && is_ovf_clr && wdata_i[0]) begin
                overflow <= 1'b0;
            end
        end
    end

    // ---------------- read path ----------------
    logic [31:0] rdata_nxt;

    always_comb begin
        rdata_nxt = '0;
        if (is_ctrl) begin
            rdata_nxt[1:0] = {continuous, global_en};
        end else if (is_conv) begin
            rdata_nxt[NumCh*ConvW-1:0] = conv_time;
        end else if (is_status) begin
            rdata_nxt[NumCh-1:0] = busy;
            rdata_nxt[8]         = fifo_empty;
            rdata_nxt[9]         = fifo_full;
            rdata_nxt[10]        = overflow;
        end else if (is_fdata) begin
            rdata_nxt = fifo_empty ? '0 : fifo_word;
        end else if (is_flevel) begin
            rdata_nxt[LvlW-1:0] = level;
        end else if (is_alarm) begin
            rdata_nxt[NumCh-1:0] = alarm;
        end else if (is_alarm_en) begin
            rdata_nxt[NumCh-1:0] = alarm_en;
        end else if (is_thresh) begin
            rdata_nxt[DoutW-1:0] = thresh;
        end else if (is_timeout) begin
            rdata_nxt[NumCh-1:0] = timeout;
        end else if (is_tmo_val) begin
            rdata_nxt[TimeoutW-1:0] = timeout_val;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_o <= '0;
            error_o <= 1'b0;
        end else begin
            rdata_o <= re_i ? rdata_nxt : '0;
            error_o <= (re_i | we_i) & ~mapped;
        end
    end

    assign sens_conv_time_o = conv_time;
    assign intr_o           = (|(alarm & alarm_en)) | overflow | (|timeout);

endmodule
`default_nettype wire
